// File: rtl/prog_ram_pkg.sv
// Shared constants and FSM state encoding for the program RAM.
package prog_ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prog_ram_ctrl.sv
// Program-load sequencer: owns the load FSM, the write pointer and the status flags.
module prog_ram_ctrl
  import prog_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic              prog_valid,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              prog_err,
  output logic              prog_wrap,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_ptr
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wrap_d  = wrap_q;
    wr_stb  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode && prog_start) begin
          state_d = LOAD;
          ptr_d   = prog_addr;
          wrap_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (!mode) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (prog_start) begin
          // restart wins over any handshake presented in the same cycle
          ptr_d   = prog_addr;
          wrap_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b1;
          if (prog_valid) begin
            wr_stb = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (&ptr_q) wrap_d = 1'b1;
            if (prog_last) begin
              state_d = DONE;
              ready_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  assign prog_ready = ready_q;
  assign prog_done  = done_q;
  assign prog_err   = err_q;
  assign prog_wrap  = wrap_q;
  assign wr_ptr     = ptr_q;

endmodule

// File: rtl/prog_ram.sv
// Program RAM: run-mode registered read onto a shared tri-state bus, plus a
// streaming program-mode loader.
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              enable,
  input  logic [ADDR_W-1:0] address,
  output tri   [DATA_W-1:0] w_bus,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              prog_start,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_done,
  output logic              prog_err,
  output logic              prog_wrap
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              prog_wr;
  logic [ADDR_W-1:0] prog_ptr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  prog_ram_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .prog_start (prog_start),
    .prog_addr  (prog_addr),
    .prog_valid (prog_valid),
    .prog_last  (prog_last),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .prog_err   (prog_err),
    .prog_wrap  (prog_wrap),
    .wr_stb     (prog_wr),
    .wr_ptr     (prog_ptr)
  );

  always_comb begin
    ram_we   = (!mode && wr_en) || prog_wr;
    ram_addr = mode ? prog_ptr : address;
    ram_data = mode ? prog_data : wr_data;
    rd_d     = mode ? rd_q : mem[address];
  end

  // Storage is deliberately not reset so a reset mid-load keeps loaded words.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  assign w_bus = enable ? {DATA_W{1'bz}} : rd_q;

endmodule
